bank_conflict_arbiter: RTL and testbench
========================================

// Module: bank_conflict_arbiter
// PURPOSE
//  Multi-cycle bank arbiter for the multilane NTT datapath. Each batch carries one bank
//  index per lane; lanes may collide on a bank. Each issue beat grants at most one lane
//  per bank, using a per-bank round-robin pick, until every lane in the batch is served.
//  Per-bank selected-lane buses feed the memory crossbar. A conflict-free batch issues in one beat.
// PARAMETERS
//  LANES  2*`P            number of requesting lanes
//  BANKS  2*`P            number of memory banks (need not be a power of 2)
//  IW     `MAP            bank-index width per lane, >= $clog2(BANKS)
//  LW     $clog2(LANES)   lane-index width (derived localparam)
//  CNTW   16              width of the conflict-stall statistics counter
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         batch valid
//  in_ready   out  1         arbiter idle, can accept a batch
//  bi_bus     in   LANES*IW  bank index of lane l at [l*IW +: IW]
//  in_mask    in   LANES     lane l participates when 1
//  out_valid  out  1         issue beat valid
//  out_ready  in   1         downstream accepts beat
//  sel_bus    out  BANKS*LW  lane granted to bank b at [b*LW +: LW]; 0 when sel_vld[b]=0
//  sel_vld    out  BANKS     bank b granted this beat
//  lane_gnt   out  LANES     lane l served this beat
//  out_last   out  1         final beat of current batch
//  err_oob    out  1         1-cycle pulse: accepted batch had an enabled lane with index >= BANKS
//  stat_clr   in   1         synchronous clear of conf_cnt
//  conf_cnt   out  CNTW      saturating count of extra beats caused by conflicts
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, rr_ptr[all banks]=0, conf_cnt=0, err_oob=0.
//   Outputs during reset: in_ready=1; out_valid, sel_vld, lane_gnt, out_last and sel_bus=0.
//  States:
//   IDLE: in_ready=1.
//    in_valid & in_ready: pending <= in_mask & ~oob, where oob[l] = bi[l] >= BANKS.
//     err_oob <= |(in_mask & oob).
//     Next state is ISSUE if the new pending != 0. Otherwise the batch is dropped:
//      stay IDLE, no beat, conf_cnt unchanged.
//   ISSUE: out_valid=1, in_ready=0.
//    Grant per bank b:
//     req_b = pending lanes with bi == b.
//     Grant the first set bit of req_b at or after rr_ptr[b], wrapping past LANES-1 to 0.
//     sel_vld[b] = |req_b; lane_gnt is the OR of all grants.
//    Outputs are decoded from registered pending, rr_ptr and the latched bi only.
//     There is no combinational path from any input to any output.
//    out_last = ((pending & ~lane_gnt) == 0).
//    On out_valid & out_ready:
//     pending <= pending & ~lane_gnt.
//     For each granted bank, rr_ptr[b] <= (granted lane + 1) mod LANES.
//     If !out_last: conf_cnt++, saturating at all-ones.
//     If out_last: next state IDLE.
//    out_ready=0: pending, rr_ptr and all outputs hold stable (beat held until accepted).
//  Latency:
//   First beat is valid in the cycle after acceptance.
//   Beats per batch = max lanes colliding on one bank.
//   Next batch can be accepted in the cycle after the last-beat handshake.
//  bi_bus is latched at acceptance and may change freely afterwards.
//  rr_ptr persists across batches; only reset clears it.
//  stat_clr has priority over a same-cycle increment (conf_cnt <= 0).
//  Reset asserted mid-batch drops the batch immediately; no beat completes.
// STRUCTURE
//  `P and `MAP come from parameter.v.
//  No new typedefs; state encoding (IDLE=0, ISSUE=1) is a localparam.
//  One sub-module: rr_lane_pick #(LANES).
//   Ports: req[LANES], ptr[LW] -> gnt_idx[LW], gnt_vld.
//   Combinational rotate-priority finder, instantiated once per bank in a generate loop.
//  Top level holds: FSM, pending/bi latch, rr_ptr array, stats counter.
// TESTING (LANES=BANKS=8 unless noted)
//  1. Lane l -> bank (l+3)%8, mask 0xFF.
//     -> One beat: sel_bus[b]=(b+5)%8, sel_vld=0xFF, out_last=1, conf_cnt=0.
//  2. All lanes -> bank 2, mask 0xFF, out_ready=1.
//     -> 8 beats granting lanes 0..7 in order; conf_cnt=7; rr_ptr[2]=0.
//     -> Repeating the batch grants lane 0 first again.
//  3. Lanes 0,1 -> bank 5 with rr_ptr[5]=1 (set by a prior single-lane-0 batch).
//     -> Beat 1 grants lane 1, beat 2 grants lane 0 with out_last=1.
//  4. Test-2 batch with out_ready=0 for 3 cycles at beat 3.
//     -> lane_gnt=0x04 held for all 3 cycles; total beats still 8.
//  5. rst_n low during beat 4 of a conflict batch.
//     -> out_valid=0 and in_ready=1 immediately; next batch behaves as after reset.
//  6. BANKS=6; lane 3 -> bank 7, other lanes distinct banks.
//     -> err_oob pulses once; lane 3 never granted; batch completes in 1 beat.
//     Also: mask=0 -> dropped, no out_valid.

Source files
------------

// File: rtl/bank_conflict_arbiter_pkg.sv
// Shared constants for the bank conflict arbiter: default geometry mirroring the
// global datapath parameter set, FSM state encoding and a small index helper.
package bank_conflict_arbiter_pkg;

  localparam int P   = 4;
  localparam int MAP = 3;

  localparam int DEF_LANES = 2 * P;
  localparam int DEF_BANKS = 2 * P;
  localparam int DEF_IW    = MAP;
  localparam int DEF_CNTW  = 16;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  // Successor of a lane index in a ring of n lanes.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/rr_lane_pick.sv
// Rotate-priority finder: returns the first set request at or after ptr,
// wrapping past LANES-1 back to lane 0.
module rr_lane_pick #(
  parameter int LANES = 8
) (
  input  logic [LANES-1:0]         req,
  input  logic [$clog2(LANES)-1:0] ptr,
  output logic [$clog2(LANES)-1:0] gnt_idx,
  output logic                     gnt_vld
);

  localparam int LW = $clog2(LANES);

  int j;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int i = 0; i < LANES; i++) begin
      j = (int'(ptr) + i) % LANES;
      if (!gnt_vld && req[LW'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = LW'(j);
      end
    end
  end

endmodule

// File: rtl/bank_conflict_arbiter.sv
// Multi-cycle bank arbiter: serialises a batch of per-lane bank requests into
// issue beats granting at most one lane per bank, round-robin per bank.
module bank_conflict_arbiter
  import bank_conflict_arbiter_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int BANKS = DEF_BANKS,
  parameter int IW    = DEF_IW,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*IW-1:0]               bi_bus,
  input  logic [LANES-1:0]                  in_mask,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BANKS*$clog2(LANES)-1:0]    sel_bus,
  output logic [BANKS-1:0]                  sel_vld,
  output logic [LANES-1:0]                  lane_gnt,
  output logic                              out_last,
  output logic                              err_oob,
  input  logic                              stat_clr,
  output logic [CNTW-1:0]                   conf_cnt
);

  localparam int LW = $clog2(LANES);

  logic                        state, state_nxt;
  logic [LANES-1:0]            pending;
  logic [LANES-1:0][IW-1:0]    bi_q;
  logic [BANKS-1:0][LW-1:0]    rr_ptr;
  logic [BANKS-1:0][LW-1:0]    pick_idx;
  logic [BANKS-1:0]            pick_vld;
  logic [BANKS-1:0][LANES-1:0] req;
  logic [LANES-1:0]            gnt_any;
  logic [LANES-1:0]            oob;
  logic [LANES-1:0]            acc_mask;
  logic                        issuing, accept, beat_done, last_beat;

  assign issuing   = (state == ST_ISSUE);
  assign accept    = in_valid && !issuing;
  assign beat_done = issuing && out_ready;

  // Out-of-range lanes are silently removed from the batch and flagged.
  always_comb begin
    oob = '0;
    for (int l = 0; l < LANES; l++)
      oob[l] = int'(bi_bus[l*IW +: IW]) >= BANKS;
  end
  assign acc_mask = in_mask & ~oob;

  // Per-bank request vectors and round-robin pickers, all from registered state.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    for (genvar l = 0; l < LANES; l++) begin : g_req
      assign req[b][l] = pending[l] && (bi_q[l] == IW'(b));
    end
    rr_lane_pick #(.LANES(LANES)) u_pick (
      .req     (req[b]),
      .ptr     (rr_ptr[b]),
      .gnt_idx (pick_idx[b]),
      .gnt_vld (pick_vld[b])
    );
  end

  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < BANKS; b++)
      if (pick_vld[b]) gnt_any[pick_idx[b]] = 1'b1;
  end

  assign last_beat = ((pending & ~gnt_any) == '0);

  always_comb begin
    sel_bus = '0;
    for (int b = 0; b < BANKS; b++)
      if (issuing && pick_vld[b]) sel_bus[b*LW +: LW] = pick_idx[b];
  end

  assign in_ready  = !issuing;
  assign out_valid = issuing;
  assign sel_vld   = issuing ? pick_vld : '0;
  assign lane_gnt  = issuing ? gnt_any  : '0;
  assign out_last  = issuing && last_beat;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && (acc_mask != '0)) state_nxt = ST_ISSUE;
      ST_ISSUE: if (beat_done && last_beat)     state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      bi_q    <= '0;
      rr_ptr  <= '0;
      err_oob <= 1'b0;
    end else begin
      err_oob <= 1'b0;
      if (accept) begin
        pending <= acc_mask;
        bi_q    <= bi_bus;
        err_oob <= |(in_mask & oob);
      end else if (beat_done) begin
        pending <= pending & ~gnt_any;
        for (int b = 0; b < BANKS; b++)
          if (pick_vld[b]) rr_ptr[b] <= LW'(wrap_inc(int'(pick_idx[b]), LANES));
      end
    end
  end

  // Every non-final beat is one beat more than a conflict-free batch would need.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          conf_cnt <= '0;
    else if (stat_clr)                                   conf_cnt <= '0;
    else if (beat_done && !last_beat && conf_cnt != '1)  conf_cnt <= conf_cnt + 1'b1;
  end

endmodule

// File: tb/tb_bank_conflict_arbiter.sv
// Directed bench: table of single-beat batches plus hand sequences for conflicts,
// back-pressure, stats clear/saturation, mid-batch reset and out-of-range lanes.
module tb_bank_conflict_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, err_oob, stat_clr;
  logic [23:0] bi_bus, sel_bus;
  logic [7:0]  in_mask, sel_vld, lane_gnt;
  logic [15:0] conf_cnt;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_last, d_err, d_clr;
  logic [23:0] d_bi;
  logic [17:0] d_sel_bus;
  logic [7:0]  d_mask, d_gnt;
  logic [5:0]  d_sel_vld;
  logic [1:0]  d_conf;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bank_conflict_arbiter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bi_bus(bi_bus),
    .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready), .sel_bus(sel_bus),
    .sel_vld(sel_vld), .lane_gnt(lane_gnt), .out_last(out_last), .err_oob(err_oob),
    .stat_clr(stat_clr), .conf_cnt(conf_cnt)
  );

  bank_conflict_arbiter #(.LANES(8), .BANKS(6), .IW(3), .CNTW(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .bi_bus(d_bi),
    .in_mask(d_mask), .out_valid(d_out_valid), .out_ready(d_out_ready), .sel_bus(d_sel_bus),
    .sel_vld(d_sel_vld), .lane_gnt(d_gnt), .out_last(d_out_last), .err_oob(d_err),
    .stat_clr(d_clr), .conf_cnt(d_conf)
  );

  typedef struct {
    logic [23:0] bi;
    logic [7:0]  mask;
    logic [23:0] sel;
    logic [7:0]  vld;
    logic [7:0]  gnt;
  } vec_t;

  vec_t vt[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [23:0] bi, input logic [7:0] m);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    chk("send_in_ready", in_ready, 1);
    in_valid = 1'b1; bi_bus = bi; in_mask = m;
    @(posedge clk); #1;
    in_valid = 1'b0; bi_bus = '1; in_mask = '0;
  endtask

  // All lanes on bank 2; optional stall or stat_clr at a given beat.
  task automatic run_b2(input int stall_k, input int clr_k);
    send(24'o22222222, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2_valid", out_valid, 1);
      chk("b2_gnt", lane_gnt, 32'(1 << k));
      chk("b2_sel", sel_bus[8:6], k);
      chk("b2_vld", sel_vld, 8'h04);
      chk("b2_last", out_last, (k == 7));
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); @(negedge clk);
          chk("stall_gnt", lane_gnt, 32'(1 << k));
          chk("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
      end
      if (k == clr_k) stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
    end
    @(negedge clk);
    chk("b2_done_valid", out_valid, 0);
    chk("b2_done_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; bi_bus = '0; in_mask = '0; out_ready = 1'b1; stat_clr = 1'b0;
    d_in_valid = 1'b0; d_bi = '0; d_mask = '0; d_out_ready = 1'b1; d_clr = 1'b0;

    vt[0] = '{24'o21076543, 8'hFF, 24'o43210765, 8'hFF, 8'hFF};
    vt[1] = '{24'o01234567, 8'h5A, 24'o01034060, 8'h5A, 8'h5A};
    vt[2] = '{24'o00000005, 8'h01, 24'o00000000, 8'h20, 8'h01};

    repeat (2) @(posedge clk); #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel_vld", sel_vld, 0);
    chk("rst_lane_gnt", lane_gnt, 0);
    chk("rst_sel_bus", sel_bus, 0);
    chk("rst_conf", conf_cnt, 0);
    chk("rst_err", err_oob, 0);
    rst_n = 1'b1;

    // Conflict-free batches: one beat each.
    for (int i = 0; i < 3; i++) begin
      send(vt[i].bi, vt[i].mask);
      @(negedge clk);
      chk("vec_valid", out_valid, 1);
      chk("vec_sel", sel_bus, vt[i].sel);
      chk("vec_vld", sel_vld, vt[i].vld);
      chk("vec_gnt", lane_gnt, vt[i].gnt);
      chk("vec_last", out_last, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("vec_idle", out_valid, 0);
    end
    chk("vec_conf", conf_cnt, 0);

    // Lanes 0,1 on bank 5 with its pointer left at 1 by the previous batch.
    send(24'o00000055, 8'h03);
    @(negedge clk);
    chk("rr5_b1_gnt", lane_gnt, 8'h02);
    chk("rr5_b1_sel", sel_bus[17:15], 1);
    chk("rr5_b1_last", out_last, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("rr5_b2_gnt", lane_gnt, 8'h01);
    chk("rr5_b2_last", out_last, 1);
    @(posedge clk); #1;
    chk("rr5_conf", conf_cnt, 1);

    run_b2(-1, -1);
    chk("b2_conf", conf_cnt, 8);
    run_b2(-1, 0);
    chk("clr_prio_conf", conf_cnt, 6);
    run_b2(2, -1);
    chk("stall_conf", conf_cnt, 13);
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    chk("clr_conf", conf_cnt, 0);

    // Dropped batch.
    send(24'o00000000, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("drop_valid", out_valid, 0);
      chk("drop_ready", in_ready, 1);
    end

    // Reset during beat 4 of a conflict batch.
    send(24'o22222222, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pre_rst_gnt", lane_gnt, 32'(1 << k));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pre_rst_conf", conf_cnt, 3);
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_gnt", lane_gnt, 0);
    chk("mid_rst_conf", conf_cnt, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    send(24'o00020200, 8'h14);
    @(negedge clk);
    chk("post_rst_b1", lane_gnt, 8'h04);
    chk("post_rst_b1_last", out_last, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("post_rst_b2", lane_gnt, 8'h10);
    chk("post_rst_b2_last", out_last, 1);
    @(posedge clk); #1;
    chk("post_rst_conf", conf_cnt, 1);

    // BANKS=6 instance: lane 3 out of range.
    @(negedge clk);
    chk("d_ready", d_in_ready, 1);
    d_in_valid = 1'b1; d_bi = 24'o56437210; d_mask = 8'hBF;
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_bi = '1; d_mask = '0;
    @(negedge clk);
    chk("oob_err", d_err, 1);
    chk("oob_valid", d_out_valid, 1);
    chk("oob_vld", d_sel_vld, 6'h3F);
    chk("oob_gnt", d_gnt, 8'hB7);
    chk("oob_sel", d_sel_bus, 18'o754210);
    chk("oob_last", d_out_last, 1);
    @(posedge clk); #1; @(negedge clk);
    chk("oob_err_pulse", d_err, 0);
    chk("oob_done", d_out_valid, 0);

    // All lanes on bank 0 (pointer at 1): starts at lane 1, counter saturates at 3.
    d_in_valid = 1'b1; d_bi = '0; d_mask = 8'hFF;
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_bi = '1; d_mask = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("sat_gnt", d_gnt, 32'(1 << ((k + 1) % 8)));
      chk("sat_last", d_out_last, (k == 7));
      @(posedge clk); #1;
    end
    chk("sat_conf", d_conf, 2'd3);

    // Mask of zero on the 6-bank instance is dropped.
    @(negedge clk);
    d_in_valid = 1'b1; d_bi = '0; d_mask = 8'h00;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("d_drop_valid", d_out_valid, 0);
      chk("d_drop_err", d_err, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
